out_fifo: RTL and testbench

OUT_FIFO -- requirements
Module: out_fifo

---
 rtl/out_fifo.sv | 124 ++++++++++++
 tb/tb_out_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : out_fifo
//  Description : Show-ahead FIFO between processor output writes and a
//                ready/valid consumer. Each entry holds {addr_out, io_out}.
//                Pushes while full are dropped (sticky ovf) unless a pop
//                happens on the same edge. Storage is not reset.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-low reset
//                io_out   - processor output data (NUBITS)
//                addr_out - processor output address ($clog2(NUIOOU))
//                out_en   - write strobe, one cycle per word
//                m_data   - head entry data
//                m_addr   - head entry address
//                m_valid  - head entry valid (level != 0)
//                m_ready  - consumer accepts the head entry
//                full     - level == FDEPTH
//                level    - current entry count (0..FDEPTH)
//                ovf      - sticky overflow flag
//                itr      - drain interrupt pulse
//  Options     : OUT_FIFO_ITR_EN - when defined, itr pulses for one cycle
//                after the FIFO drains from 1 entry to 0; otherwise itr = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fifo #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUBITS-1:0]           io_out,
    input  logic [$clog2(NUIOOU)-1:0]   addr_out,
    input  logic                        out_en,
    output logic [NUBITS-1:0]           m_data,
    output logic [$clog2(NUIOOU)-1:0]   m_addr,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        full,
    output logic [$clog2(FDEPTH+1)-1:0] level,
    output logic                        ovf,
    output logic                        itr
);

    localparam int AW = $clog2(NUIOOU);
    localparam int PW = $clog2(FDEPTH);
    localparam int LW = $clog2(FDEPTH + 1);
    localparam int EW = AW + NUBITS;

    localparam logic [LW-1:0] c_lvl_full = LW'(FDEPTH);
    localparam logic [LW-1:0] c_lvl_one  = LW'(1);

    logic [EW-1:0] r_mem [FDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ovf;

    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_level == c_lvl_full);
    assign w_pop     = (r_level != '0) && m_ready;
    // A push at full is legal only when the head leaves on the same edge.
    assign w_push_ok = out_en && (!w_full || w_pop);

    // Storage carries no reset; validity is tracked by r_level alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {addr_out, io_out};
        end
    end

    // Pointers wrap naturally because FDEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (out_en && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef OUT_FIFO_ITR_EN
    logic r_itr;

    // Drain event: last entry popped with no replacement pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_itr <= 1'b0;
        end else begin
            r_itr <= w_pop && !w_push_ok && (r_level == c_lvl_one);
        end
    end

    assign itr = r_itr;
`else
    assign itr = 1'b0;
`endif

    assign {m_addr, m_data} = r_mem[r_rptr];
    assign m_valid          = (r_level != '0);
    assign full             = w_full;
    assign level            = r_level;
    assign ovf              = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_fifo
//  Description : Directed self-checking bench for out_fifo (16-bit, 2
//                addresses, depth 8). Honours OUT_FIFO_ITR_EN for itr checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_fifo;

    localparam int NUBITS = 16;
    localparam int NUIOOU = 2;
    localparam int FDEPTH = 8;

    logic        clk;
    logic        rst;
    logic [15:0] io_out;
    logic [0:0]  addr_out;
    logic        out_en;
    logic [15:0] m_data;
    logic [0:0]  m_addr;
    logic        m_valid;
    logic        m_ready;
    logic        full;
    logic [3:0]  level;
    logic        ovf;
    logic        itr;

    int n_pass;
    int n_total;

    out_fifo #(
        .NUBITS (NUBITS),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .full     (full),
        .level    (level),
        .ovf      (ovf),
        .itr      (itr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

`ifdef OUT_FIFO_ITR_EN
    localparam logic c_itr_on = 1'b1;
`else
    localparam logic c_itr_on = 1'b0;
`endif

    // Advance one rising edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic a, input logic rdy);
        io_out   = d;
        addr_out = a;
        out_en   = 1'b1;
        m_ready  = rdy;
        step();
        out_en   = 1'b0;
        m_ready  = 1'b0;
    endtask

    task automatic do_reset();
        out_en  = 1'b0;
        m_ready = 1'b0;
        rst     = 1'b0;
        step();
        rst     = 1'b1;
        #2;
    endtask

    // Pop and check 'n' words starting from value base+first, addr = index % 2.
    task automatic drain_seq(input logic [15:0] base, input int first, input int n, input string nm);
        m_ready = 1'b1;
        for (int i = first; i < first + n; i++) begin
            n_total++;
            if (m_valid !== 1'b1 || m_data !== base + 16'(i) || m_addr !== 1'(i % 2)) begin
                $display("FAIL %s[%0d]: actual v=%b d=%h a=%b required v=1 d=%h a=%b",
                         nm, i, m_valid, m_data, m_addr, base + 16'(i), 1'(i % 2));
            end else begin
                n_pass++;
            end
            step();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; out_en = 1'b0; m_ready = 1'b0; io_out = '0; addr_out = '0;
        step();
        step();
        n_total++;
        if ({m_valid, full, level, ovf, itr} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: actual v=%b f=%b l=%0d o=%b i=%b required 0 0 0 0 0",
                     m_valid, full, level, ovf, itr);
        end else n_pass++;
        rst = 1'b1;
        #2;
        // First edge after release must take the push.
        push(16'hA5A5, 1'b1, 1'b0);
        n_total++;
        if (level !== 4'd1 || m_data !== 16'hA5A5 || m_addr !== 1'b1) begin
            $display("FAIL first_push: actual l=%0d d=%h a=%b required l=1 d=a5a5 a=1", level, m_data, m_addr);
        end else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [3];
        logic        exp_a [3];
        exp_d[0] = 16'h1111; exp_a[0] = 1'b0;
        exp_d[1] = 16'h2222; exp_a[1] = 1'b1;
        exp_d[2] = 16'h3333; exp_a[2] = 1'b0;
        do_reset();
        push(exp_d[0], exp_a[0], 1'b0);
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 16'h1111) begin
            $display("FAIL basic_latency: actual v=%b d=%h required v=1 d=1111", m_valid, m_data);
        end else n_pass++;
        push(exp_d[1], exp_a[1], 1'b0);
        push(exp_d[2], exp_a[2], 1'b0);
        step();
        n_total++;
        if (level !== 4'd3 || m_data !== 16'h1111 || m_addr !== 1'b0) begin
            $display("FAIL basic_level_hold: actual l=%0d d=%h a=%b required l=3 d=1111 a=0", level, m_data, m_addr);
        end else n_pass++;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_addr !== exp_a[i]) begin
                $display("FAIL basic_pop[%0d]: actual v=%b d=%h a=%b required v=1 d=%h a=%b",
                         i, m_valid, m_data, m_addr, exp_d[i], exp_a[i]);
            end else n_pass++;
            step();
        end
        m_ready = 1'b0;
        n_total++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            $display("FAIL basic_empty: actual v=%b l=%0d required v=0 l=0", m_valid, level);
        end else n_pass++;
    endtask

    task automatic fill8(input logic [15:0] base);
        for (int i = 0; i < 8; i++) push(base + 16'(i), 1'(i % 2), 1'b0);
    endtask

    task automatic test_fill_ovf();
        do_reset();
        fill8(16'h1000);
        n_total++;
        if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b0) begin
            $display("FAIL fill_full: actual f=%b l=%0d o=%b required f=1 l=8 o=0", full, level, ovf);
        end else n_pass++;
        push(16'hDEAD, 1'b1, 1'b0);
        n_total++;
        if (ovf !== 1'b1 || level !== 4'd8 || m_data !== 16'h1000 || full !== 1'b1) begin
            $display("FAIL overflow: actual o=%b l=%0d d=%h f=%b required o=1 l=8 d=1000 f=1", ovf, level, m_data, full);
        end else n_pass++;
        drain_seq(16'h1000, 0, 8, "ovf_drain");
        n_total++;
        if (m_valid !== 1'b0 || ovf !== 1'b1) begin
            $display("FAIL ovf_sticky: actual v=%b o=%b required v=0 o=1", m_valid, ovf);
        end else n_pass++;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        fill8(16'h2000);
        push(16'hBEEF, 1'b0, 1'b1);
        n_total++;
        if (level !== 4'd8 || ovf !== 1'b0 || full !== 1'b1 || m_data !== 16'h2001) begin
            $display("FAIL full_pushpop: actual l=%0d o=%b f=%b d=%h required l=8 o=0 f=1 d=2001", level, ovf, full, m_data);
        end else n_pass++;
        drain_seq(16'h2000, 1, 7, "fpp_drain");
        n_total++;
        if (m_data !== 16'hBEEF || m_addr !== 1'b0 || level !== 4'd1) begin
            $display("FAIL fpp_last: actual d=%h a=%b l=%0d required d=beef a=0 l=1", m_data, m_addr, level);
        end else n_pass++;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_empty_pushpop();
        do_reset();
        push(16'h0042, 1'b1, 1'b1);
        n_total++;
        if (level !== 4'd1 || m_valid !== 1'b1 || m_data !== 16'h0042 || m_addr !== 1'b1) begin
            $display("FAIL empty_pushpop: actual l=%0d v=%b d=%h a=%b required l=1 v=1 d=0042 a=1",
                     level, m_valid, m_data, m_addr);
        end else n_pass++;
        // Mid-level push+pop keeps level and advances head.
        push(16'h0043, 1'b0, 1'b1);
        n_total++;
        if (level !== 4'd1 || m_data !== 16'h0043) begin
            $display("FAIL mid_pushpop: actual l=%0d d=%h required l=1 d=0043", level, m_data);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill8(16'h3000);
        push(16'hDEAD, 1'b0, 1'b0);
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        n_total++;
        if (level !== 4'd5 || ovf !== 1'b1) begin
            $display("FAIL pre_reset: actual l=%0d o=%b required l=5 o=1", level, ovf);
        end else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (m_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || full !== 1'b0) begin
            $display("FAIL async_reset: actual v=%b l=%0d o=%b f=%b required 0 0 0 0", m_valid, level, ovf, full);
        end else n_pass++;
        out_en = 1'b1; io_out = 16'h7777; m_ready = 1'b1;
        step();
        out_en = 1'b0; m_ready = 1'b0;
        n_total++;
        if (level !== 4'd0 || m_valid !== 1'b0) begin
            $display("FAIL push_in_reset: actual l=%0d v=%b required l=0 v=0", level, m_valid);
        end else n_pass++;
        rst = 1'b1;
        #2;
        push(16'h5A5A, 1'b1, 1'b0);
        n_total++;
        if (level !== 4'd1 || m_data !== 16'h5A5A || m_addr !== 1'b1) begin
            $display("FAIL post_reset_push: actual l=%0d d=%h a=%b required l=1 d=5a5a a=1", level, m_data, m_addr);
        end else n_pass++;
    endtask

    task automatic test_itr();
        logic exp_itr [4];
        exp_itr[0] = 1'b0; exp_itr[1] = c_itr_on; exp_itr[2] = 1'b0; exp_itr[3] = 1'b0;
        do_reset();
        push(16'h0001, 1'b0, 1'b0);
        push(16'h0002, 1'b1, 1'b0);
        n_total++;
        if (itr !== 1'b0) begin
            $display("FAIL itr_idle: actual %b required 0", itr);
        end else n_pass++;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (itr !== exp_itr[i]) begin
                $display("FAIL itr_pulse[%0d]: actual %b required %b", i, itr, exp_itr[i]);
            end else n_pass++;
        end
        m_ready = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_fill_ovf();
        test_full_pushpop();
        test_empty_pushpop();
        test_reset_mid();
        test_itr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
